pixel_hex_writer: RTL

PIXEL_HEX_WRITER -- requirements
Module: pixel_hex_writer

---
 rtl/pixel_hex_writer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pixel_hex_writer.sv
// rtl/pixel_hex_writer.sv - pixel FIFO plus hex-text serializer ("xx\n" per pixel)
//
// Purpose: accepts processed pixel bytes into a small FIFO and prints each one as
// two lowercase hex digits followed by a newline. It also counts the pixels it has
// fully emitted and pulses frame_done when a frame wraps.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   pix_in      [0:7] pixel byte, bit 0 = MSB
//   pix_valid   pix_in holds a pixel
//   pix_ready   FIFO can accept a pixel (registered-state decode)
//   char_out    ASCII character to the text sink
//   char_valid  char_out holds a character
//   char_ready  sink takes char_out this cycle
//   frame_done  one-cycle pulse after the last pixel of a frame is emitted
//   pix_count   pixels fully emitted in the current frame
module pixel_hex_writer #(
  parameter int FRAME_PIXELS = 98304,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:7]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        frame_done,
  output logic [16:0] pix_count
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [16:0]     LAST_PIXEL = 17'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, HI, LO, NL} state_t;

  logic [0:7]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_nx;
  logic [0:7]    pix_hold;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};  // 0x57 + 10 = 'a'
  endfunction

  // ---------------- pixel FIFO ----------------
  assign fifo_empty = (count == '0);
  assign pix_ready  = (count != FULL_COUNT);
  assign push       = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;  // idle, or push and pop cancel out
      endcase
    end
  end

  // ---------------- serializer FSM ----------------
  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    char_valid = 1'b0;
    char_out   = 8'h00;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = HI;
        end
      end
      HI: begin
        char_valid = 1'b1;
        char_out   = hex_ascii(pix_hold[0:3]);
        if (char_ready) state_nx = LO;
      end
      LO: begin
        char_valid = 1'b1;
        char_out   = hex_ascii(pix_hold[4:7]);
        if (char_ready) state_nx = NL;
      end
      NL: begin
        char_valid = 1'b1;
        char_out   = 8'h0A;
        if (char_ready) begin
          // Chain straight into the next pixel so a busy stream has no gaps.
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = HI;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pix_hold <= '0;
    end else begin
      state <= state_nx;
      if (pop) pix_hold <= mem[rd_ptr];
    end
  end

  // ---------------- frame counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == NL && char_ready) begin
        if (pix_count == LAST_PIXEL) begin
          pix_count  <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_count <= pix_count + 17'd1;
        end
      end
    end
  end

endmodule
